// File: rtl/tile_text_writer_pkg.sv
// Shared definitions for the tile text writer and the VGA scan-out path:
// screen geometry defaults, FSM state encoding and control-code constants.
package tile_text_writer_pkg;

   localparam int TILE_COLS       = 80;
   localparam int TILE_ROWS       = 60;
   localparam int TILE_ADDR_WIDTH = 13;
   localparam int TILE_DATA_WIDTH = 8;
   localparam int COL_WIDTH       = 7;
   localparam int ROW_WIDTH       = 6;

   localparam logic [7:0] CHAR_BS    = 8'h08;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam logic [7:0] CHAR_FF    = 8'h0C;
   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_BLANK = 8'h20;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SCROLL_RD,
      SCROLL_WR,
      BLANK
   } state_t;

endpackage

// File: rtl/tile_text_writer.sv
// Console-style writer that owns port A of the tile BRAM: prints characters,
// handles control codes, scrolls one row up and clears the whole screen.
module tile_text_writer
   import tile_text_writer_pkg::*;
#(
   parameter int COLS       = TILE_COLS,
   parameter int ROWS       = TILE_ROWS,
   parameter int ADDR_WIDTH = TILE_ADDR_WIDTH,
   parameter int DATA_WIDTH = TILE_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  char_valid,
   input  logic [DATA_WIDTH-1:0] char_data,
   output logic                  char_ready,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_wdata,
   input  logic [DATA_WIDTH-1:0] bram_rdata,
   output logic [COL_WIDTH-1:0]  cursor_col,
   output logic [ROW_WIDTH-1:0]  cursor_row
);

   localparam logic [ADDR_WIDTH-1:0] LAST_TILE = ADDR_WIDTH'(ROWS * COLS - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_COPY = ADDR_WIDTH'((ROWS - 1) * COLS - 1);
   localparam logic [ADDR_WIDTH-1:0] COLS_A    = ADDR_WIDTH'(COLS);
   localparam logic [COL_WIDTH-1:0]  LAST_COL  = COL_WIDTH'(COLS - 1);
   localparam logic [ROW_WIDTH-1:0]  LAST_ROW  = ROW_WIDTH'(ROWS - 1);
   localparam logic [DATA_WIDTH-1:0] BLANK_CH  = DATA_WIDTH'(CHAR_BLANK);

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] cur_addr, cur_next;
   logic [ADDR_WIDTH-1:0] idx, idx_next;
   logic [COL_WIDTH-1:0]  col_next;
   logic [ROW_WIDTH-1:0]  row_next;
   logic                  clear_pending, pending_next;
   logic                  we_next, copy_q, copy_next;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_next;
   logic [ADDR_WIDTH-1:0] col_a;
   logic                  start_clear, accept, is_print, last_col, last_row;

   assign start_clear = clear_req || clear_pending;
   assign char_ready  = (state == IDLE) && !start_clear;
   assign accept      = char_valid && char_ready;
   assign busy        = (state != IDLE);
   assign is_print    = (char_data >= DATA_WIDTH'(8'h20)) && (char_data <= DATA_WIDTH'(8'h7E));
   assign last_col    = (cursor_col == LAST_COL);
   assign last_row    = (cursor_row == LAST_ROW);
   assign col_a       = ADDR_WIDTH'(cursor_col);

   // The copy write lands one cycle after its read address was on the bus, so
   // its data comes straight from the BRAM read port rather than a register.
   assign bram_wdata  = copy_q ? bram_rdata : wdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_clear) begin
               state_next = CLEAR;
            end else if (accept) begin
               if (char_data == DATA_WIDTH'(CHAR_FF))
                  state_next = CLEAR;
               else if (last_row && ((char_data == DATA_WIDTH'(CHAR_LF)) || (is_print && last_col)))
                  state_next = SCROLL_RD;
            end
         end
         CLEAR:     if (idx == LAST_TILE) state_next = IDLE;
         SCROLL_RD: state_next = SCROLL_WR;
         SCROLL_WR: state_next = (idx == LAST_COPY) ? BLANK : SCROLL_RD;
         BLANK:     if (idx == LAST_TILE) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      we_next    = 1'b0;
      addr_next  = bram_addr;
      wdata_next = wdata_q;
      copy_next  = 1'b0;
      case (state)
         IDLE: begin
            if (accept && is_print) begin
               we_next    = 1'b1;
               addr_next  = cur_addr;
               wdata_next = char_data;
            end else if (accept && (char_data == DATA_WIDTH'(CHAR_BS)) && (cursor_col != '0)) begin
               we_next    = 1'b1;
               addr_next  = cur_addr - 1'b1;
               wdata_next = BLANK_CH;
            end
         end
         CLEAR, BLANK: begin
            we_next    = 1'b1;
            addr_next  = idx;
            wdata_next = BLANK_CH;
         end
         SCROLL_RD: addr_next = idx + COLS_A;
         SCROLL_WR: begin
            we_next   = 1'b1;
            addr_next = idx;
            copy_next = 1'b1;
         end
         default: ;
      endcase
   end

   // Cursor and linear address move together; cur_addr tracks row*COLS+col
   // using only add/subtract of the column or COLS.
   always_comb begin
      col_next     = cursor_col;
      row_next     = cursor_row;
      cur_next     = cur_addr;
      idx_next     = idx;
      pending_next = clear_pending;
      if (clear_req && (state != IDLE)) pending_next = 1'b1;
      case (state)
         IDLE: begin
            if (start_clear || (accept && (char_data == DATA_WIDTH'(CHAR_FF)))) begin
               col_next     = '0;
               row_next     = '0;
               cur_next     = '0;
               idx_next     = '0;
               pending_next = 1'b0;
            end else if (accept && is_print) begin
               if (!last_col) begin
                  col_next = cursor_col + 1'b1;
                  cur_next = cur_addr + 1'b1;
               end else if (!last_row) begin
                  col_next = '0;
                  row_next = cursor_row + 1'b1;
                  cur_next = cur_addr + 1'b1;
               end else begin
                  col_next = '0;
                  cur_next = cur_addr - ADDR_WIDTH'(COLS - 1);
                  idx_next = '0;
               end
            end else if (accept && (char_data == DATA_WIDTH'(CHAR_LF))) begin
               col_next = '0;
               if (last_row) begin
                  cur_next = cur_addr - col_a;
                  idx_next = '0;
               end else begin
                  row_next = cursor_row + 1'b1;
                  cur_next = cur_addr - col_a + COLS_A;
               end
            end else if (accept && (char_data == DATA_WIDTH'(CHAR_CR))) begin
               col_next = '0;
               cur_next = cur_addr - col_a;
            end else if (accept && (char_data == DATA_WIDTH'(CHAR_BS)) && (cursor_col != '0)) begin
               col_next = cursor_col - 1'b1;
               cur_next = cur_addr - 1'b1;
            end
         end
         CLEAR, SCROLL_WR, BLANK: idx_next = idx + 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cursor_col    <= '0;
         cursor_row    <= '0;
         cur_addr      <= '0;
         idx           <= '0;
         clear_pending <= 1'b0;
         bram_we       <= 1'b0;
         bram_addr     <= '0;
         wdata_q       <= '0;
         copy_q        <= 1'b0;
      end else begin
         cursor_col    <= col_next;
         cursor_row    <= row_next;
         cur_addr      <= cur_next;
         idx           <= idx_next;
         clear_pending <= pending_next;
         bram_we       <= we_next;
         bram_addr     <= addr_next;
         wdata_q       <= wdata_next;
         copy_q        <= copy_next;
      end
   end

endmodule
